// File: rtl/icache_pkg.sv
// Shared geometry, fill-FSM state type and address-split helpers for the
// fetch-side direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned ADDR_W     = 36;
  localparam int unsigned SETS       = 64;
  localparam int unsigned LINE_WORDS = 4;

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {IDLE, REQ, FILL, COMMIT} icache_state_t;

  function automatic logic [IDX_W-1:0] get_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr >> (OFF_W + 2));
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return TAG_W'(addr >> (IDX_W + OFF_W + 2));
  endfunction

  function automatic logic [OFF_W-1:0] get_off(input logic [ADDR_W-1:0] addr);
    return OFF_W'(addr >> 2);
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(LINE_WORDS * 4 - 1);
  endfunction

endpackage

// File: rtl/icache_fill_fsm.sv
// Miss controller: latches the missing line, runs the request/response
// handshake with memory and sequences the array writes for the line fill.
module icache_fill_fsm
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              flush,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  output logic              busy,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [TAG_W-1:0]  fill_tag,
  output logic              inval_en,
  output logic              wr_en,
  output logic [OFF_W-1:0]  wr_word,
  output logic              commit_en,
  output logic              commit_valid
);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  icache_state_t     state_q, state_d;
  logic [ADDR_W-1:0] line_q;
  logic [OFF_W-1:0]  beat_q;
  logic              flush_pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    inval_en      = 1'b0;
    wr_en         = 1'b0;
    commit_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss) state_d = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        // Victim line is dropped as the fill begins so partial data never hits.
        if (mem_req_ready) begin
          state_d  = FILL;
          inval_en = 1'b1;
        end
      end
      FILL: begin
        if (mem_resp_valid) begin
          wr_en = 1'b1;
          if (beat_q == LAST_BEAT) state_d = COMMIT;
        end
      end
      COMMIT: begin
        commit_en = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q          <= '0;
      beat_q          <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      if (state_q == IDLE && miss) line_q <= line_addr(miss_addr);

      if (state_q == COMMIT) begin
        beat_q <= '0;
      end else if (state_q == FILL && mem_resp_valid) begin
        beat_q <= beat_q + 1'b1;
      end

      if (state_q == COMMIT) begin
        flush_pending_q <= 1'b0;
      end else if (flush && state_q != IDLE) begin
        flush_pending_q <= 1'b1;
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign mem_req_addr = line_q;
  assign fill_idx     = get_idx(line_q);
  assign fill_tag     = get_tag(line_q);
  assign wr_word      = beat_q;
  // A flush landing on the commit cycle itself must also leave the line invalid.
  assign commit_valid = !flush_pending_q && !flush;

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped instruction cache with zero-latency combinational lookup;
// misses are refilled a line at a time by icache_fill_fsm.
module icache_fetch_ctrl
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic [31:0]       instr,
  output logic              hit_valid,
  output logic              cache_stall,
  output logic              misalign,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][LINE_WORDS];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [OFF_W-1:0] lk_off;
  logic             line_hit;
  logic             miss;

  logic             busy;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             inval_en;
  logic             wr_en;
  logic [OFF_W-1:0] wr_word;
  logic             commit_en;
  logic             commit_valid;

  // Outputs are qualified by rst_n so everything reads 0 while reset is held.
  always_comb begin
    lk_idx      = get_idx(req_addr);
    lk_tag      = get_tag(req_addr);
    lk_off      = get_off(req_addr);
    line_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    misalign    = rst_n && req_valid && (req_addr[1:0] != 2'b00);
    hit_valid   = rst_n && req_valid && !misalign && !flush && line_hit;
    cache_stall = rst_n && ((req_valid && !hit_valid && !misalign) || busy);
    miss        = req_valid && !hit_valid && !misalign && !busy;
    instr       = hit_valid ? data_q[lk_idx][lk_off] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (inval_en) begin
      valid_q[fill_idx] <= 1'b0;
    end else if (commit_en) begin
      valid_q[fill_idx] <= commit_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) data_q[fill_idx][wr_word] <= mem_resp_data;
    if (commit_en) tag_q[fill_idx] <= fill_tag;
  end

  icache_fill_fsm u_fill_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .miss           (miss),
    .miss_addr      (req_addr),
    .flush          (flush),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .busy           (busy),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .fill_idx       (fill_idx),
    .fill_tag       (fill_tag),
    .inval_en       (inval_en),
    .wr_en          (wr_en),
    .wr_word        (wr_word),
    .commit_en      (commit_en),
    .commit_valid   (commit_valid)
  );

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Self-checking bench: directed scenarios plus randomized fetches, checked
// against a line-residency model of the cache and a synthetic memory image.
module tb_icache_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [35:0] req_addr;
  logic        flush;
  logic [31:0] instr;
  logic        hit_valid;
  logic        cache_stall;
  logic        misalign;
  logic        mem_req_valid;
  logic [35:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic [31:0] seed;
  bit          model_valid [64];
  logic [35:0] model_line  [64];
  logic [35:0] pool        [8];

  always #5 clk = ~clk;

  icache_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .flush          (flush),
    .instr          (instr),
    .hit_valid      (hit_valid),
    .cache_stall    (cache_stall),
    .misalign       (misalign),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  function automatic logic [35:0] line_of(input logic [35:0] a);
    return a & ~36'hF;
  endfunction

  function automatic int set_of(input logic [35:0] a);
    return int'((a >> 4) % 64);
  endfunction

  // Memory image: line 0x100 holds AAAA0000+word, everything else is hashed.
  function automatic logic [31:0] mem_word(input logic [35:0] a);
    logic [35:0] la;
    logic [31:0] w;
    la = line_of(a);
    w  = 32'((a >> 2) % 4);
    if (la == 36'h100) return 32'hAAAA0000 + w;
    return (32'(la >> 4) * 32'h9E3779B1) ^ seed ^ w;
  endfunction

  function automatic bit model_hit(input logic [35:0] a);
    return model_valid[set_of(a)] && (model_line[set_of(a)] == line_of(a));
  endfunction

  function automatic logic [35:0] rand_addr();
    logic [35:0] a;
    a = pool[$urandom_range(0, 7)] + 36'(4 * $urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) a = a + 36'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected lookup-side outputs for the current inputs and model state.
  task automatic check_cycle(input string tag, input bit busy);
    bit mis, hit, stall;
    mis   = req_valid && (req_addr[1:0] != 2'b00);
    hit   = req_valid && !mis && !flush && model_hit(req_addr);
    stall = (req_valid && !hit && !mis) || busy;
    chk({tag, ".misalign"}, 64'(misalign), 64'(mis));
    chk({tag, ".hit"}, 64'(hit_valid), 64'(hit));
    chk({tag, ".stall"}, 64'(cache_stall), 64'(stall));
    if (hit) chk({tag, ".instr"}, 64'(instr), 64'(mem_word(req_addr)));
  endtask

  // Lookup only: req_valid is withdrawn before the clock edge so no miss starts.
  task automatic probe(input logic [35:0] a);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    #1;
    check_cycle("probe", 1'b0);
    #1;
    req_valid = 1'b0;
  endtask

  // One fetch; on a miss, serve the refill with the given backpressure,
  // inter-beat gap, optional flush after beat fb (3 = during commit) and
  // optional wandering of req_addr while stalled.
  task automatic fetch(input logic [35:0] a, input int rdly, input int gap,
                       input int fb, input bit wander);
    logic [35:0] la;
    int          idx;
    bit          pend;
    la   = line_of(a);
    idx  = set_of(a);
    pend = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    flush     = 1'b0;
    #1;
    check_cycle("lookup", 1'b0);
    if (a[1:0] != 2'b00) begin
      @(negedge clk);
      #1;
      chk("misalign.no_req", 64'(mem_req_valid), 64'd0);
      check_cycle("misalign.idle", 1'b0);
      req_valid = 1'b0;
      return;
    end
    if (model_hit(a)) begin
      #1;
      req_valid = 1'b0;
      return;
    end
    for (int i = 0; i <= rdly; i++) begin
      @(negedge clk);
      mem_req_ready = (i == rdly);
      if (wander) req_addr = rand_addr();
      #1;
      check_cycle("req", 1'b1);
      chk("req.valid", 64'(mem_req_valid), 64'd1);
      chk("req.addr", 64'(mem_req_addr), 64'(la));
    end
    model_valid[idx] = 1'b0;
    for (int w = 0; w < 4; w++) begin
      for (int g = 0; g <= gap; g++) begin
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = (g == gap);
        mem_resp_data  = (g == gap) ? mem_word(la + 36'(4 * w)) : $urandom;
        flush          = (w >= 1) && (fb == w - 1) && (g == 0);
        req_addr       = (wander && !(w == 3 && g == gap)) ? rand_addr() : a;
        #1;
        check_cycle("fill", 1'b1);
        chk("fill.req_valid", 64'(mem_req_valid), 64'd0);
        if (flush) begin
          model_clear();
          pend = 1'b1;
        end
      end
    end
    @(negedge clk);
    mem_resp_valid = 1'($urandom_range(0, 1));
    mem_resp_data  = $urandom;
    flush          = (fb == 3);
    req_addr       = a;
    #1;
    check_cycle("commit", 1'b1);
    if (flush) begin
      model_clear();
      pend = 1'b1;
    end
    model_valid[idx] = !pend;
    model_line[idx]  = la;
    @(negedge clk);
    flush          = 1'b0;
    mem_resp_valid = 1'b0;
    #1;
    check_cycle("refetch", 1'b0);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seed           = $urandom;
    pool[0]        = 36'h100;
    pool[1]        = 36'h100 + 36'(64 * 16);
    pool[2]        = 36'h200;
    pool[3]        = 36'h340;
    pool[4]        = 36'h5A0;
    pool[5]        = 36'h123456780;
    pool[6]        = 36'hF00000100;
    pool[7]        = 36'h0000007F0;
    model_clear();
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_addr       = '0;
    flush          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;

    #1;
    chk("rst.hit", 64'(hit_valid), 64'd0);
    chk("rst.stall", 64'(cache_stall), 64'd0);
    chk("rst.misalign", 64'(misalign), 64'd0);
    chk("rst.mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst.mem_req_addr", 64'(mem_req_addr), 64'd0);
    chk("rst.instr", 64'(instr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss on 0x100, then hits on words 0 and 3.
    fetch(36'h100, 2, 0, -1, 1'b0);
    probe(36'h100);
    probe(36'h10C);

    // Long backpressure and two-cycle beat gaps.
    fetch(36'h200, 5, 2, -1, 1'b0);
    probe(36'h208);

    // Same-set conflict evicts and refills, with req_addr wandering.
    fetch(36'h100 + 36'(64 * 16), 1, 1, -1, 1'b0);
    probe(36'h100);
    fetch(36'h100, 1, 1, -1, 1'b1);
    probe(36'h104);

    // Flush after beat 1: the filled line ends invalid, as do all others.
    fetch(36'h340, 0, 1, 1, 1'b0);
    probe(36'h340);
    probe(36'h100);
    probe(36'h200);
    fetch(36'h340, 0, 0, -1, 1'b0);
    fetch(36'h5A0, 0, 0, 3, 1'b0);
    probe(36'h5A4);

    // Flush while idle clears resident lines.
    fetch(36'h200, 0, 0, -1, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    #1;
    model_clear();
    @(negedge clk);
    flush = 1'b0;
    probe(36'h200);

    // Reset while the request is outstanding.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 36'h7F0;
    #1;
    check_cycle("rstmiss.lookup", 1'b0);
    @(negedge clk);
    #1;
    chk("rstmiss.req_valid", 64'(mem_req_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmiss.req_drop", 64'(mem_req_valid), 64'd0);
    chk("rstmiss.stall", 64'(cache_stall), 64'd0);
    chk("rstmiss.hit", 64'(hit_valid), 64'd0);
    model_clear();
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    fetch(36'h7F0, 1, 0, -1, 1'b0);

    // Misaligned fetch and stray response data while idle.
    fetch(36'h102, 0, 0, -1, 1'b0);
    fetch(36'h100, 0, 0, -1, 1'b0);
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEADBEEF;
    #1;
    chk("stray.req_valid", 64'(mem_req_valid), 64'd0);
    chk("stray.stall", 64'(cache_stall), 64'd0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    probe(36'h100);
    probe(36'h10C);

    for (int n = 0; n < 40; n++) begin
      fetch(rand_addr(), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
            1'($urandom_range(0, 1)));
      probe(rand_addr());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
